// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared constants, state type and helpers for the fetch unit
//
// Purpose : common definitions imported by ifu_fetch and ifu_pc_reg.
// Contents: XLEN, RESET_PC_DEFAULT, PC_STEP, ifu_state_e, align_pc().
package npc_pkg;

  localparam int XLEN = 32;

  // First fetch address after reset unless the top is overridden.
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // Sequential fetch stride (one 32-bit instruction).
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  // Clears the two byte-offset bits; instructions are word aligned.
  localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request being offered to instruction memory
    WAIT  = 2'd1,  // request accepted, response outstanding
    HOLD  = 2'd2   // instruction offered to decode
  } ifu_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// rtl/ifu_pc_reg.sv - program counter register with redirect / pc+4 / hold mux
//
// Purpose : holds the fetch pc; a redirect wins over a sequential advance.
// Ports   :
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset, loads RESET_PC
//   i_redirect      in   load i_redirect_pc (word aligned) this cycle
//   i_redirect_pc   in   redirect target, bits [1:0] ignored
//   i_advance       in   step pc by 4 (wraps modulo 2^32)
//   o_pc            out  current pc, bits [1:0] always zero
module ifu_pc_reg
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_advance,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = align_pc(i_redirect_pc);
    end else if (i_advance) begin
      // Natural 32-bit overflow gives the FFFF_FFFC -> 0 wrap.
      w_pc_next = r_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= align_pc(RESET_PC);
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - single-outstanding instruction fetch unit
//
// Purpose : fetches one instruction at a time from instruction memory and
//           offers it to decode; redirects from execute override everything.
// Ports   :
//   clk             in   clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   mem_req_valid   out  fetch request valid
//   mem_req_addr    out  fetch address (the pc register)
//   mem_req_ready   in   memory accepts the request
//   mem_rsp_valid   in   read data valid
//   mem_rsp_data    in   fetched instruction word
//   inst_valid      out  instruction offered to decode
//   inst            out  instruction word
//   inst_pc         out  address of inst
//   inst_ready      in   decode consumes inst
//   redirect_valid  in   control-flow change from execute
//   redirect_pc     in   new fetch address, bits [1:0] ignored
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  ifu_state_e      r_state;
  logic            r_drop;     // outstanding response belongs to a squashed path
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;

  logic [XLEN-1:0] w_pc;
  logic            w_advance;
  logic            w_req_fire;

  // Decode consumed the held instruction and no redirect squashed it.
  assign w_advance  = (r_state == HOLD) && inst_ready && !redirect_valid;

  // Redirect suppresses the request in the same cycle so the stale pc is
  // never accepted by memory.
  assign w_req_fire = (r_state == FETCH) && !redirect_valid && mem_req_ready;

  ifu_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_redirect    (redirect_valid),
    .i_redirect_pc (redirect_pc),
    .i_advance     (w_advance),
    .o_pc          (w_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_drop    <= 1'b0;
      r_inst    <= '0;
      r_inst_pc <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          if (w_req_fire) begin
            r_state <= WAIT;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            if (mem_rsp_valid) begin
              // The in-flight response lands in the redirect cycle: discard
              // it now, nothing remains outstanding.
              r_drop  <= 1'b0;
              r_state <= FETCH;
            end else begin
              r_drop  <= 1'b1;
            end
          end else if (mem_rsp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= FETCH;
            end else begin
              r_inst    <= mem_rsp_data;
              r_inst_pc <= w_pc;
              r_state   <= HOLD;
            end
          end
        end

        HOLD: begin
          if (redirect_valid || inst_ready) begin
            r_state <= FETCH;
          end
        end

        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  // rst_n gates the request so nothing is offered while reset is held even
  // though the state register already sits in FETCH.
  assign mem_req_valid = rst_n && (r_state == FETCH) && !redirect_valid;
  assign mem_req_addr  = w_pc;
  assign inst_valid    = (r_state == HOLD) && !redirect_valid;
  assign inst          = r_inst;
  assign inst_pc       = r_inst_pc;

endmodule
